state_reader: RTL

STATE_READER -- requirements
Module: state_reader

---
 rtl/atom_pkg.sv | 15 +
 rtl/fifo2.sv | 73 +++++++
 rtl/state_reader.sv | 75 +++++++
 3 files changed

// File: rtl/atom_pkg.sv
// Shared definitions for the state-atom blocks.
//   CountWidth : default width of a state value and of the packet field.
//   entry_t    : one buffered read result, {read value, pkt field}, read value in the MSBs.
package atom_pkg;

  localparam int unsigned CountWidth = 3;

  typedef struct packed {
    logic [CountWidth-1:0] read_pff;
    logic [CountWidth-1:0] pkt_1;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

endpackage

// File: rtl/fifo2.sv
// Two-entry valid/ready FIFO with an async active-low reset.
// Ports:
//   clk, rst_n             clock and reset
//   push_valid_i/ready_o   write handshake; push_data_i is captured on a push
//   pop_valid_o/ready_i    read handshake; pop_data_o is the head entry
//   count_o                occupancy, 0..2
// Entry 0 is always the head. Empty slots are kept at zero, so pop_data_o reads
// as zero whenever the FIFO is empty without extra output muxing.
module fifo2 #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [Width-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [Width-1:0] pop_data_o,
  output logic [1:0]       count_o
);

  localparam logic [1:0] Full = 2'(Depth);

  logic [Width-1:0] slot0_q, slot0_d;
  logic [Width-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // Ready depends on registered occupancy only, never on pop_ready_i.
  assign push_ready_o = (count_q != Full);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = slot0_q;
  assign count_o      = count_q;

  assign push = push_valid_i & push_ready_o;
  assign pop  = pop_valid_o & pop_ready_i;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (push && pop) begin
      // Only reachable with one entry: the new entry replaces the old head.
      slot0_d = push_data_i;
    end else if (pop) begin
      slot0_d = slot1_q;
      slot1_d = '0;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        slot0_d = push_data_i;
      end else begin
        slot1_d = push_data_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/state_reader.sv
// State reader: holds one state register written by the write atom and answers
// read requests by capturing the current state plus the request's packet field
// into a two-entry output buffer.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i__write__pff, i__write_en  state write (never back-pressured)
//   i__pkt_valid, o__pkt_ready  read request handshake, i__pkt_1 rides along
//   o__read_valid, i__read_ready result handshake
//   o__read__pff, o__pkt_1      head result (zero when the buffer is empty)
//   o__count                    buffer occupancy, 0..2
module state_reader
  import atom_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = atom_pkg::CountWidth,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COUNT_WIDTH-1:0] i__write__pff,
  input  logic                   i__write_en,
  input  logic                   i__pkt_valid,
  input  logic [COUNT_WIDTH-1:0] i__pkt_1,
  output logic                   o__pkt_ready,
  output logic                   o__read_valid,
  input  logic                   i__read_ready,
  output logic [COUNT_WIDTH-1:0] o__read__pff,
  output logic [COUNT_WIDTH-1:0] o__pkt_1,
  output logic [1:0]             o__count
);

  // Same field layout as atom_pkg::entry_t, sized by COUNT_WIDTH.
  typedef struct packed {
    logic [COUNT_WIDTH-1:0] read_pff;
    logic [COUNT_WIDTH-1:0] pkt_1;
  } rd_entry_t;

  logic [COUNT_WIDTH-1:0] r__state;
  rd_entry_t              push_entry;
  rd_entry_t              head_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r__state <= '0;
    end else if (i__write_en) begin
      r__state <= i__write__pff;
    end
  end

  // Captured from the pre-edge register, so a coincident write is not seen
  // by the request pushed on the same edge.
  always_comb begin
    push_entry          = '0;
    push_entry.read_pff = r__state;
    push_entry.pkt_1    = i__pkt_1;
  end

  fifo2 #(
    .Width (2 * COUNT_WIDTH),
    .Depth (DEPTH)
  ) u_fifo2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (i__pkt_valid),
    .push_ready_o (o__pkt_ready),
    .push_data_i  (push_entry),
    .pop_valid_o  (o__read_valid),
    .pop_ready_i  (i__read_ready),
    .pop_data_o   (head_entry),
    .count_o      (o__count)
  );

  assign o__read__pff = head_entry.read_pff;
  assign o__pkt_1     = head_entry.pkt_1;

endmodule
